// File: rtl/ram_ctrl_pkg.sv
// Shared types for the multi-channel RAM controller: FSM state encoding and
// the response pipeline entry carried from acceptance to response.
package ram_ctrl_pkg;

  localparam int CH_ID_W = 3;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    INIT = 1'b1
  } state_e;

  typedef struct packed {
    logic               vld;
    logic [CH_ID_W-1:0] ch;
    logic               rd;
    logic               err;
  } pipe_t;

  localparam pipe_t PIPE_IDLE = '{vld: 1'b0, ch: 3'd0, rd: 1'b0, err: 1'b0};

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer with wrap-around;
// the pointer moves past the winner only when the grant is taken.
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_gidx;
  logic [PW-1:0] w_ptr_nxt;

  // Walk offsets from farthest to nearest so the nearest requester wins
  always_comb begin
    int unsigned w_sum;
    grant  = '0;
    w_gidx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_sum  = 32'(r_ptr) + 32'(k);
      w_sum  = (w_sum >= 32'(NUM_CH)) ? (w_sum - 32'(NUM_CH)) : w_sum;
      grant  = req[w_sum[PW-1:0]] ? (NUM_CH'(1) << w_sum[PW-1:0]) : grant;
      w_gidx = req[w_sum[PW-1:0]] ? w_sum[PW-1:0] : w_gidx;
    end
  end

  assign w_ptr_nxt = (w_gidx == PW'(NUM_CH - 1)) ? '0 : (w_gidx + PW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (advance && (|grant)) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/ram_mc_ctrl.sv
// Multi-channel RAM controller: round-robin access to a single-port RAM with
// per-channel response routing and a zero-fill sweep on request.
module ram_mc_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 256,
  parameter int RD_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            req_valid,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH-1:0]            req_we,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_CH-1:0]            rsp_valid,
  output logic                         rsp_err,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  input  logic                         init_start,
  output logic                         init_busy,
  output logic [ADDR_WIDTH-1:0]        ram_address,
  output logic                         ram_cs,
  output logic                         ram_we,
  output logic                         ram_oe,
  output logic [DATA_WIDTH-1:0]        ram_wdata,
  input  logic [DATA_WIDTH-1:0]        ram_rdata
);

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  pipe_t                 r_pipe [RD_LATENCY];

  logic                  w_run;
  logic                  w_in_init;
  logic [NUM_CH-1:0]     w_req;
  logic [NUM_CH-1:0]     w_grant;
  logic                  w_acc;
  logic [CH_ID_W-1:0]    w_gch;
  logic                  w_gwe;
  logic [ADDR_WIDTH-1:0] w_gaddr;
  logic [DATA_WIDTH-1:0] w_gwdata;
  logic                  w_inrange;
  pipe_t                 w_tail;
  pipe_t                 w_head;

  // Gating with rst_n keeps the combinational outputs quiet while in reset
  assign w_run     = rst_n & (r_state == RUN);
  assign w_in_init = rst_n & (r_state == INIT);
  assign w_req     = req_valid & {NUM_CH{w_run}};

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (w_req),
    .advance (w_acc),
    .grant   (w_grant)
  );

  assign req_ready = w_grant;
  assign w_acc     = |w_grant;

  // Grant is one-hot, so an AND-OR mux selects the winning channel's fields
  always_comb begin
    w_gch    = '0;
    w_gwe    = 1'b0;
    w_gaddr  = '0;
    w_gwdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_gch    = w_gch | (CH_ID_W'(i) & {CH_ID_W{w_grant[i]}});
      w_gwe    = w_gwe | (req_we[i] & w_grant[i]);
      w_gaddr  = w_gaddr | (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{w_grant[i]}});
      w_gwdata = w_gwdata | (req_wdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_grant[i]}});
    end
  end

  assign w_inrange = ({1'b0, w_gaddr} < (ADDR_WIDTH + 1)'(RAM_DEPTH));

  always_comb begin
    if (w_in_init) begin
      ram_cs      = 1'b1;
      ram_we      = 1'b1;
      ram_oe      = 1'b0;
      ram_address = r_cnt;
      ram_wdata   = '0;
    end else if (w_acc && w_inrange) begin
      ram_cs      = 1'b1;
      ram_we      = w_gwe;
      ram_oe      = ~w_gwe;
      ram_address = w_gaddr;
      ram_wdata   = w_gwdata;
    end else begin
      ram_cs      = 1'b0;
      ram_we      = 1'b0;
      ram_oe      = 1'b0;
      ram_address = '0;
      ram_wdata   = '0;
    end
  end

  assign w_tail = '{vld: w_acc,
                    ch:  w_gch,
                    rd:  w_acc & ~w_gwe & w_inrange,
                    err: w_acc & ~w_inrange};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LATENCY; k++) begin
        r_pipe[k] <= PIPE_IDLE;
      end
    end else begin
      r_pipe[0] <= w_tail;
      for (int k = 1; k < RD_LATENCY; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  // The sweep owns the RAM for exactly RAM_DEPTH cycles; init_start is ignored meanwhile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (init_start) begin
            r_state <= INIT;
            r_cnt   <= '0;
          end
        end
        INIT: begin
          if (r_cnt == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + ADDR_WIDTH'(1);
          end
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign w_head = r_pipe[RD_LATENCY-1];

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rsp_valid[i] = w_head.vld & (w_head.ch == CH_ID_W'(i));
    end
  end

  assign rsp_err   = w_head.vld & w_head.err;
  assign rsp_rdata = (w_head.vld & w_head.rd) ? ram_rdata : '0;
  assign init_busy = (r_state == INIT);

endmodule

// File: tb/tb_ram_mc_ctrl.sv
// Scoreboard bench for ram_mc_ctrl: two instances (default, and depth 200 with
// read latency 2) sharing a clock, each backed by a behavioural RAM.
module tb_ram_mc_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [3:0]  req_valid   [2];
  logic [3:0]  req_ready   [2];
  logic [3:0]  req_we      [2];
  logic [31:0] req_addr    [2];
  logic [63:0] req_wdata   [2];
  logic [3:0]  rsp_valid   [2];
  logic        rsp_err     [2];
  logic [15:0] rsp_rdata   [2];
  logic        init_start  [2];
  logic        init_busy   [2];
  logic [7:0]  ram_address [2];
  logic        ram_cs      [2];
  logic        ram_we      [2];
  logic        ram_oe      [2];
  logic [15:0] ram_wdata   [2];
  logic [15:0] ram_rdata   [2];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int          dut;
    int          ch;
    logic        err;
    logic [15:0] rdata;
    int          due;
  } exp_t;

  exp_t        exp_q [$];
  logic [3:0]  grant_log [$];
  bit          log_en = 1'b0;
  int          rsp_cnt [4];
  int          busy_cnt = 0;

  // Reference model state
  logic [15:0] m_mem  [2][256];
  int          m_ptr  [2];
  bit          m_init [2];
  int          m_idx  [2];

  // Behavioural RAM state
  logic [15:0] ram_mem [2][256];
  logic [15:0] rd_p1   [2];
  logic [15:0] rd_p2   [2];
  logic        mem_loaded = 1'b0;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int depth_of(input int d);
    return (d == 0) ? 256 : 200;
  endfunction

  function automatic logic [15:0] pat(input int a);
    return 16'(a) ^ 16'hC3C3;
  endfunction

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ram_mc_ctrl #(.NUM_CH(4), .DATA_WIDTH(16), .ADDR_WIDTH(8), .RAM_DEPTH(256), .RD_LATENCY(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_err(rsp_err[0]), .rsp_rdata(rsp_rdata[0]),
    .init_start(init_start[0]), .init_busy(init_busy[0]),
    .ram_address(ram_address[0]), .ram_cs(ram_cs[0]), .ram_we(ram_we[0]), .ram_oe(ram_oe[0]),
    .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0])
  );

  ram_mc_ctrl #(.NUM_CH(4), .DATA_WIDTH(16), .ADDR_WIDTH(8), .RAM_DEPTH(200), .RD_LATENCY(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_err(rsp_err[1]), .rsp_rdata(rsp_rdata[1]),
    .init_start(init_start[1]), .init_busy(init_busy[1]),
    .ram_address(ram_address[1]), .ram_cs(ram_cs[1]), .ram_we(ram_we[1]), .ram_oe(ram_oe[1]),
    .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1])
  );

  // Synchronous-write RAM; read data is captured at the strobe edge and delayed per instance
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int d = 0; d < 2; d++) begin
        for (int a = 0; a < 256; a++) begin
          ram_mem[d][a] <= pat(a);
        end
      end
      mem_loaded <= 1'b1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (ram_cs[d] && ram_we[d]) ram_mem[d][ram_address[d]] <= ram_wdata[d];
      end
    end
    for (int d = 0; d < 2; d++) begin
      rd_p1[d] <= (ram_cs[d] && ram_oe[d]) ? ram_mem[d][ram_address[d]] : 16'hDEAD;
      rd_p2[d] <= rd_p1[d];
    end
  end

  assign ram_rdata[0] = rd_p1[0];
  assign ram_rdata[1] = rd_p2[1];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: compare responses against the queue, then predict this cycle's grant/RAM strobe
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        int          g;
        logic [3:0]  exp_ready;
        logic [7:0]  a;
        logic        we;
        logic [15:0] wd;
        exp_t        e;

        if (rsp_valid[d] != 4'b0000) begin
          if (exp_q.size() == 0 || exp_q[0].dut != d) begin
            check_val("rsp_unexpected", {60'd0, rsp_valid[d]}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check_val("rsp_valid", {60'd0, rsp_valid[d]}, {60'd0, 4'b0001 << e.ch});
            check_val("rsp_err", {63'd0, rsp_err[d]}, {63'd0, e.err});
            check_val("rsp_rdata", {48'd0, rsp_rdata[d]}, {48'd0, e.rdata});
            check_val("rsp_cycle", 64'(cyc), 64'(e.due));
            if (d == 0) rsp_cnt[e.ch]++;
          end
        end
        while (exp_q.size() > 0 && exp_q[0].dut == d && exp_q[0].due < cyc) begin
          check_val("rsp_missing", 64'(cyc), 64'(exp_q[0].due));
          e = exp_q.pop_front();
        end

        if (d == 0 && init_busy[0]) busy_cnt++;

        if (m_init[d]) begin
          check_val("init_ready", {60'd0, req_ready[d]}, 64'd0);
          check_val("init_busy", {63'd0, init_busy[d]}, 64'd1);
          check_val("init_cs", {63'd0, ram_cs[d]}, 64'd1);
          check_val("init_we", {63'd0, ram_we[d]}, 64'd1);
          check_val("init_addr", {56'd0, ram_address[d]}, 64'(m_idx[d]));
          check_val("init_wdata", {48'd0, ram_wdata[d]}, 64'd0);
          m_mem[d][m_idx[d]] = 16'h0000;
          if (m_idx[d] == depth_of(d) - 1) begin
            m_init[d] = 1'b0;
            m_idx[d]  = 0;
          end else begin
            m_idx[d]++;
          end
        end else begin
          check_val("run_busy", {63'd0, init_busy[d]}, 64'd0);
          g = -1;
          for (int k = 3; k >= 0; k--) begin
            if (req_valid[d][(m_ptr[d] + k) % 4]) g = (m_ptr[d] + k) % 4;
          end
          exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
          check_val("grant", {60'd0, req_ready[d]}, {60'd0, exp_ready});
          if (d == 0 && log_en && req_ready[0] != 4'b0000) grant_log.push_back(req_ready[0]);
          if (g >= 0) begin
            a  = req_addr[d][g*8 +: 8];
            we = req_we[d][g];
            wd = req_wdata[d][g*16 +: 16];
            e.dut = d;
            e.ch  = g;
            e.due = cyc + lat_of(d);
            if (int'(a) < depth_of(d)) begin
              check_val("ram_cs", {63'd0, ram_cs[d]}, 64'd1);
              check_val("ram_we", {63'd0, ram_we[d]}, {63'd0, we});
              check_val("ram_oe", {63'd0, ram_oe[d]}, {63'd0, ~we});
              check_val("ram_addr", {56'd0, ram_address[d]}, {56'd0, a});
              if (we) check_val("ram_wdata", {48'd0, ram_wdata[d]}, {48'd0, wd});
              e.err   = 1'b0;
              e.rdata = we ? 16'h0000 : m_mem[d][a];
              if (we) m_mem[d][a] = wd;
            end else begin
              check_val("oor_cs", {63'd0, ram_cs[d]}, 64'd0);
              e.err   = 1'b1;
              e.rdata = 16'h0000;
            end
            exp_q.push_back(e);
            m_ptr[d] = (g + 1) % 4;
          end else begin
            check_val("idle_cs", {63'd0, ram_cs[d]}, 64'd0);
          end
          if (init_start[d]) begin
            m_init[d] = 1'b1;
            m_idx[d]  = 0;
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int d, input int ch, input logic we, input logic [7:0] a, input logic [15:0] wd);
    req_valid[d][ch]          = 1'b1;
    req_we[d][ch]             = we;
    req_addr[d][ch*8 +: 8]    = a;
    req_wdata[d][ch*16 +: 16] = wd;
  endtask

  task automatic clear_req(input int d);
    req_valid[d] = 4'b0000;
  endtask

  task automatic check_idle(input int d);
    check_val("rst_ready", {60'd0, req_ready[d]}, 64'd0);
    check_val("rst_rsp_valid", {60'd0, rsp_valid[d]}, 64'd0);
    check_val("rst_rsp_err", {63'd0, rsp_err[d]}, 64'd0);
    check_val("rst_rsp_rdata", {48'd0, rsp_rdata[d]}, 64'd0);
    check_val("rst_init_busy", {63'd0, init_busy[d]}, 64'd0);
    check_val("rst_ram_cs", {63'd0, ram_cs[d]}, 64'd0);
    check_val("rst_ram_we", {63'd0, ram_we[d]}, 64'd0);
    check_val("rst_ram_oe", {63'd0, ram_oe[d]}, 64'd0);
    check_val("rst_ram_addr", {56'd0, ram_address[d]}, 64'd0);
    check_val("rst_ram_wdata", {48'd0, ram_wdata[d]}, 64'd0);
  endtask

  task automatic model_reset;
    for (int d = 0; d < 2; d++) begin
      m_ptr[d]  = 0;
      m_init[d] = 1'b0;
      m_idx[d]  = 0;
    end
    exp_q.delete();
  endtask

  initial begin
    bit found;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 4'b0000; req_we[d] = 4'b0000;
      req_addr[d] = 32'd0; req_wdata[d] = 64'd0; init_start[d] = 1'b0;
      for (int a = 0; a < 256; a++) m_mem[d][a] = pat(a);
    end
    for (int c = 0; c < 4; c++) rsp_cnt[c] = 0;
    model_reset();

    // Reset state, with requests pending to show ready stays low
    repeat (3) @(posedge clk);
    #1;
    req_valid[0] = 4'b1111;
    #1;
    check_idle(0);
    check_idle(1);
    clear_req(0);
    rst_n = 1'b1;
    tick();

    // Write 0x1234 to address 5, then read it back
    set_req(0, 0, 1'b1, 8'd5, 16'h1234); tick();
    clear_req(0); tick();
    set_req(0, 0, 1'b0, 8'd5, 16'h0000); tick();
    clear_req(0); repeat (3) tick();

    // Out-of-range and boundary addresses with depth 200
    set_req(1, 2, 1'b0, 8'd210, 16'h0000); tick();
    clear_req(1); set_req(1, 2, 1'b1, 8'd199, 16'hBEEF); tick();
    clear_req(1); set_req(1, 2, 1'b0, 8'd199, 16'h0000); tick();
    clear_req(1); set_req(1, 1, 1'b0, 8'd200, 16'h0000); tick();
    clear_req(1); set_req(1, 0, 1'b1, 8'd255, 16'h7777); tick();
    clear_req(1); repeat (4) tick();

    // Back-to-back reads at latency 2 from channels 1 and 2
    set_req(1, 1, 1'b1, 8'd10, 16'hAAAA); tick();
    clear_req(1); set_req(1, 2, 1'b1, 8'd11, 16'h5555); tick();
    clear_req(1); set_req(1, 1, 1'b0, 8'd10, 16'h0000); tick();
    clear_req(1); set_req(1, 2, 1'b0, 8'd11, 16'h0000); tick();
    clear_req(1); repeat (4) tick();

    // Contended random traffic at latency 2
    for (int n = 0; n < 8; n++) begin
      for (int c = 0; c < 4; c++) begin
        set_req(1, c, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 16'($urandom));
      end
      tick();
    end
    clear_req(1); repeat (4) tick();

    // Fill 0..3, start the sweep with a concurrent read, poke init_start again mid-sweep
    for (int i = 0; i < 4; i++) begin
      set_req(0, 3, 1'b1, 8'(i), 16'h1000 + 16'(i)); tick();
    end
    clear_req(0);
    busy_cnt = 0;
    init_start[0] = 1'b1;
    set_req(0, 1, 1'b0, 8'd2, 16'h0000); tick();
    init_start[0] = 1'b0; clear_req(0);
    repeat (5) tick();
    init_start[0] = 1'b1;
    req_valid[0] = 4'b1111;
    repeat (2) tick();
    init_start[0] = 1'b0; clear_req(0);
    repeat (256) tick();
    check_val("init_busy_cycles", 64'(busy_cnt), 64'd256);
    for (int i = 0; i < 4; i++) begin
      set_req(0, 0, 1'b0, 8'(i), 16'h0000); tick();
    end
    clear_req(0); repeat (3) tick();

    // Reset in the middle of a sweep
    init_start[0] = 1'b1; tick();
    init_start[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      if (init_busy[0] && ram_address[0] == 8'd100) found = 1'b1;
    end
    check_val("sweep_reach_100", {63'd0, found}, 64'd1);
    for (int c = 0; c < 4; c++) set_req(0, c, 1'b0, 8'(16 + c), 16'h0000);
    rst_n = 1'b0;
    #1;
    check_idle(0);
    check_idle(1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) rsp_cnt[c] = 0;
    grant_log.delete();
    log_en = 1'b1;
    rst_n  = 1'b1;

    // All four channels requesting for 8 cycles straight out of reset
    repeat (8) tick();
    clear_req(0);
    log_en = 1'b0;
    repeat (3) tick();
    check_val("grant_count", 64'(grant_log.size()), 64'd8);
    for (int i = 0; i < grant_log.size(); i++) begin
      check_val("grant_order", {60'd0, grant_log[i]}, {60'd0, 4'b0001 << (i % 4)});
    end
    for (int c = 0; c < 4; c++) check_val("rsp_per_channel", 64'(rsp_cnt[c]), 64'd2);

    repeat (5) tick();
    check_val("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_mc_ctrl.md
RAM_MC_CTRL -- requirements
Module: ram_mc_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of requesting channels, range 1..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: RAM word width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8: address width.
REQ-004 SHALL have parameter RAM_DEPTH, default 256: number of valid words, at most 2**ADDR_WIDTH.
REQ-005 SHALL have parameter RD_LATENCY, default 1: RAM read latency in cycles, 1 or 2.
REQ-006 SHALL have ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_CH  per-channel request valid.
- req_ready  out  NUM_CH  per-channel request accepted this cycle.
- req_we  in  NUM_CH  1 = write, 0 = read.
- req_addr  in  NUM_CH*ADDR_WIDTH  packed per-channel address; channel i uses slice i.
- req_wdata  in  NUM_CH*DATA_WIDTH  packed per-channel write data.
- rsp_valid  out  NUM_CH  one-cycle response pulse to the owning channel.
- rsp_err  out  1  response is for an out-of-range address.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- init_start  in  1  pulse: start clearing the RAM.
- init_busy  out  1  clear sweep in progress.
- ram_address  out  ADDR_WIDTH  RAM address.
- ram_cs, ram_we, ram_oe  out  1 each  RAM chip select, write enable, output enable.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid RD_LATENCY cycles after a read strobe.

Function
REQ-007 SHALL implement an FSM with states RUN and INIT, entering RUN out of reset.
REQ-008 In RUN, SHALL grant at most one channel per cycle: req_ready[i]=1 only for the granted channel, combinational from req_valid and the round-robin pointer.
REQ-009 Round-robin SHALL search from channel ptr upward with wrap-around; after a grant to channel g, ptr becomes (g+1) mod NUM_CH; ptr is unchanged when nothing is granted.
REQ-010 A request SHALL be accepted when req_valid[i] and req_ready[i] are both 1 at a clock edge.
REQ-011 An in-range request (addr < RAM_DEPTH) SHALL drive ram_cs=1, ram_we=req_we, ram_oe=!req_we, plus ram_address and ram_wdata, combinationally in the acceptance cycle; ram_cs=0 otherwise.
REQ-012 An out-of-range request SHALL hold ram_cs=0 in its acceptance cycle.
REQ-013 Every accepted request SHALL produce exactly one rsp_valid pulse on its own channel, RD_LATENCY cycles after the acceptance edge, writes included.
- rsp_err=1 only for out-of-range requests.
- rsp_rdata=ram_rdata for in-range reads, 0 otherwise.
REQ-014 Channel id, read flag and error flag SHALL travel through an RD_LATENCY-deep shift pipeline; back-to-back acceptances on consecutive cycles SHALL be sustained at full throughput.
REQ-015 init_start seen in RUN SHALL move the FSM to INIT on the next edge.
REQ-016 In INIT:
- req_ready=0 on all channels and init_busy=1.
- One write of 0 per cycle to addresses 0..RAM_DEPTH-1 in order.
- After writing address RAM_DEPTH-1, return to RUN.
REQ-017 init_start during INIT SHALL be ignored.
REQ-018 Responses already in the pipeline when INIT starts SHALL still be delivered at their scheduled cycles.
REQ-019 When init_start and req_valid occur in the same RUN cycle, the request SHALL still be granted and INIT starts on the next cycle.

Reset
REQ-020 Asserting rst_n low SHALL asynchronously clear, even mid-sweep or with responses in flight:
- state to RUN, ptr to 0, sweep counter to 0, and the pipeline.
- outputs: req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, init_busy=0, ram_cs=ram_we=ram_oe=0, ram_address=0, ram_wdata=0.
REQ-021 Pending responses SHALL be discarded by reset.

Structure
REQ-022 Package ram_ctrl_pkg SHALL hold the FSM state enum (RUN, INIT) and the pipeline-entry struct (channel id, read flag, error flag).
REQ-023 Round-robin arbitration SHALL be a sub-module rr_arbiter, parametrised by NUM_CH, with ports req, grant and advance.

Verification
REQ-024 Single channel 0 writes 0x1234 to address 5, then reads address 5 -> with RD_LATENCY=1, rsp_valid[0] pulses one cycle after the read acceptance with rsp_rdata=0x1234 and rsp_err=0.
REQ-025 All 4 channels hold req_valid for 8 cycles -> grants go in order 0,1,2,3,0,1,2,3, and each channel receives 2 responses.
REQ-026 RAM_DEPTH=200 and a read of address 210 -> ram_cs stays 0, and rsp_valid pulses with rsp_err=1 and rsp_rdata=0.
REQ-027 init_start after addresses 0..3 are written -> init_busy is high for exactly 256 cycles, then reads of addresses 0..3 return 0.
REQ-028 RD_LATENCY=2 with back-to-back reads from channels 1 and 2 -> responses arrive on consecutive cycles, in the same order as the reads were accepted.
REQ-029 rst_n pulsed low mid-sweep at address 100 -> all outputs are 0 immediately, and the FSM is in RUN with ptr=0 after release.
